// File: rtl/display_pkg.sv
// Shared scan-state type, display timing and frame-stage constants.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WRAP = 2'd2
  } scan_state_e;

  localparam int H_ACTIVE = 300;
  localparam int H_FP     = 8;
  localparam int H_SYNC   = 16;
  localparam int H_BP     = 16;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 100;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 6;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W = 10;
  localparam int IND_W = 16;

  localparam int FRAME_PIXELS = 30000;

  // Crop geometry the frame store stage uses to fetch from the source buffer.
  localparam int SRC_STRIDE  = 330;
  localparam int CROP_OFFSET = 3330;

endpackage

// File: rtl/scan_counter.sv
// Wrapping counter with enable, synchronous clear, terminal-count flag and a
// registered flag that is high while the count sits inside [WIN_LO, WIN_HI).
module scan_counter #(
  parameter int WIDTH  = 10,
  parameter int MAX    = 339,
  parameter int WIN_LO = 1,
  parameter int WIN_HI = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] next_o,
  output logic             tc_o,
  output logic             win_o
);

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);
  localparam logic [WIDTH-1:0] LO_C    = WIDTH'(WIN_LO);
  localparam logic [WIDTH-1:0] HI_C    = WIDTH'(WIN_HI);
  localparam logic             WIN_AT0 = (WIN_LO == 0) && (WIN_HI > 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             win_q, win_d;

  // Clear has priority; otherwise step when enabled, wrapping after MAX.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == MAX_C) ? '0 : count_q + ONE_C;
    end
    win_d = (count_d >= LO_C) && (count_d < HI_C);
  end

  // Count and window flag are registered together so they always agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      win_q   <= WIN_AT0;
    end else begin
      count_q <= count_d;
      win_q   <= win_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;
  assign tc_o    = (count_q == MAX_C);
  assign win_o   = win_q;

endmodule

// File: rtl/display_scan_gen.sv
// Scan timing and read-address generator feeding the frame crop/store stage.
// Every output is derived from next-state values and registered, so all of
// them describe the same PxOut/LineOut in the same cycle.
module display_scan_gen
  import display_pkg::scan_state_e, display_pkg::IDLE, display_pkg::SCAN,
         display_pkg::WRAP, display_pkg::CNT_W, display_pkg::IND_W;
#(
  parameter int H_ACTIVE   = display_pkg::H_ACTIVE,
  parameter int H_FP       = display_pkg::H_FP,
  parameter int H_SYNC     = display_pkg::H_SYNC,
  parameter int H_BP       = display_pkg::H_BP,
  parameter int V_ACTIVE   = display_pkg::V_ACTIVE,
  parameter int V_FP       = display_pkg::V_FP,
  parameter int V_SYNC     = display_pkg::V_SYNC,
  parameter int V_BP       = display_pkg::V_BP,
  parameter int CONTINUOUS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             FrameReady,
  input  logic             Enable,
  output logic [CNT_W-1:0] PxOut,
  output logic [CNT_W-1:0] LineOut,
  output logic             readFrame,
  output logic [IND_W-1:0] FrameWInd,
  output logic             HSync,
  output logic             VSync,
  output logic             FrameDone,
  output logic             Busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_ACTIVE - 1);
  localparam logic [IND_W-1:0] IND_ONE  = IND_W'(1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : gen_bad_timing
    $error("display_scan_gen: H_TOTAL or V_TOTAL does not fit 10-bit counters");
  end

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] pxNext, lnNext;
  logic             hTc, vTc, hWin, vWin;
  logic             advance, counterClear;
  logic             readFrame_q, readFrame_d;
  logic [IND_W-1:0] frameWInd_q, frameWInd_d;
  logic             frameDone_q, frameDone_d;
  logic             busy_q, busy_d;

  assign advance      = (state_q == SCAN) && Enable;
  assign counterClear = (state_d != SCAN);

  scan_counter #(
    .WIDTH (CNT_W),
    .MAX   (H_TOTAL - 1),
    .WIN_LO(H_ACTIVE + H_FP),
    .WIN_HI(H_ACTIVE + H_FP + H_SYNC)
  ) u_hcount (
    .clk    (clk),
    .reset  (reset),
    .clear_i(counterClear),
    .en_i   (advance),
    .count_o(PxOut),
    .next_o (pxNext),
    .tc_o   (hTc),
    .win_o  (hWin)
  );

  scan_counter #(
    .WIDTH (CNT_W),
    .MAX   (V_TOTAL - 1),
    .WIN_LO(V_ACTIVE + V_FP),
    .WIN_HI(V_ACTIVE + V_FP + V_SYNC)
  ) u_vcount (
    .clk    (clk),
    .reset  (reset),
    .clear_i(counterClear),
    .en_i   (advance && hTc),
    .count_o(LineOut),
    .next_o (lnNext),
    .tc_o   (vTc),
    .win_o  (vWin)
  );

  // Scan sequencing: start on a ready frame, leave SCAN after the last blanking
  // position, and decide in WRAP whether to rescan or go idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (FrameReady && Enable) state_d = SCAN;
      SCAN:    if (advance && hTc && vTc) state_d = WRAP;
      WRAP:    state_d = ((CONTINUOUS != 0) && FrameReady) ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; the read index steps only when
  // the scan moves onto an active pixel, so no multiply is needed.
  always_comb begin
    readFrame_d = (state_d == SCAN) && (pxNext < H_ACT_C) && (lnNext < V_ACT_C);
    frameWInd_d = frameWInd_q;
    if ((state_d != SCAN) || (state_q != SCAN)) begin
      frameWInd_d = '0;
    end else if (advance && readFrame_d) begin
      frameWInd_d = frameWInd_q + IND_ONE;
    end
    frameDone_d = advance && readFrame_q && (PxOut == H_LAST_C) && (LineOut == V_LAST_C);
    busy_d      = (state_d == SCAN);
  end

  // State and output registers, cleared together so reset aborts a scan at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      readFrame_q <= 1'b0;
      frameWInd_q <= '0;
      frameDone_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      readFrame_q <= readFrame_d;
      frameWInd_q <= frameWInd_d;
      frameDone_q <= frameDone_d;
      busy_q      <= busy_d;
    end
  end

  assign readFrame = readFrame_q;
  assign FrameWInd = frameWInd_q;
  assign HSync     = ~hWin;
  assign VSync     = ~vWin;
  assign FrameDone = frameDone_q;
  assign Busy      = busy_q;

endmodule

// File: doc/display_scan_gen.md
Name: display_scan_gen

Overview:
- Timing and address generator directly upstream of the frame crop/store stage.
- Once the writer reports a full frame loaded, scans a 300x100 active window plus blanking, one pixel per clk.
- Drives PxOut, LineOut, readFrame and the linear read index FrameWInd into the crop/store stage.
- Also emits HSync/VSync for the display side and a FrameDone pulse.

Parameters:
- H_ACTIVE, 300, active pixels per line
- H_FP, 8, horizontal front porch (clks)
- H_SYNC, 16, horizontal sync width (clks)
- H_BP, 16, horizontal back porch (clks); H_TOTAL = 340
- V_ACTIVE, 100, active lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 6, vertical back porch (lines); V_TOTAL = 110
- CONTINUOUS, 0, 1 = rescan frames back-to-back; 0 = one frame per FrameReady

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- FrameReady  in  1  level; writer has a complete frame in the buffer
- Enable  in  1  scan advances only when 1 (pause when 0)
- PxOut  out  10  horizontal counter, 0..H_TOTAL-1
- LineOut  out  10  vertical counter, 0..V_TOTAL-1
- readFrame  out  1  1 when PxOut < H_ACTIVE and LineOut < V_ACTIVE
- FrameWInd  out  16  linear active-pixel index, LineOut*H_ACTIVE + PxOut, valid when readFrame=1
- HSync  out  1  active-low; 0 when H_ACTIVE+H_FP <= PxOut < H_ACTIVE+H_FP+H_SYNC
- VSync  out  1  active-low; same rule on LineOut with V_* parameters
- FrameDone  out  1  one-clk pulse, cycle after the last active pixel (index 29999)
- Busy  out  1  1 while in SCAN

Behaviour:
- Reset values: PxOut=0, LineOut=0, readFrame=0, FrameWInd=0, HSync=1, VSync=1, FrameDone=0, Busy=0, state IDLE. Reset mid-scan aborts immediately to these values.
- All outputs are registered and mutually consistent in the same cycle. readFrame, FrameWInd, HSync and VSync all describe the current PxOut/LineOut.
- FSM states:
  - IDLE: counters held at 0, readFrame=0. Go to SCAN on the first clk with FrameReady=1 and Enable=1. PxOut=0, LineOut=0, readFrame=1 and FrameWInd=0 appear on the following cycle.
  - SCAN: on each clk with Enable=1, PxOut increments. At H_TOTAL-1, PxOut wraps to 0 and LineOut increments. At the last position (H_TOTAL-1, V_TOTAL-1), go to WRAP.
  - SCAN with Enable=0: every output holds its value. readFrame stays asserted if currently active, so the consumer must itself qualify with Enable.
  - WRAP (one cycle, counters 0, readFrame=0): if CONTINUOUS=1 and FrameReady=1, return to SCAN; otherwise go to IDLE.
- FrameWInd:
  - Maintained incrementally: +1 on each active pixel advance; holds during blanking.
  - Cleared to 0 at frame start.
  - Never multiplied in RTL. Range 0..29999 and never wraps within a frame.
- FrameDone:
  - Asserted for exactly one clk, on the first advance after FrameWInd=29999 with readFrame=1 (i.e. PxOut 299 -> 300 on line 99).
  - Not re-asserted while paused.
- FrameReady deasserted mid-scan: the current frame completes; the change is only sampled in IDLE and WRAP.
- Counter widths: 10 bits suffice for 340/110. Parameter sets with H_TOTAL or V_TOTAL > 1024 are illegal and flagged by an elaboration-time check.

Decomposition:
- Shared package display_pkg:
  - scan-state enum (IDLE, SCAN, WRAP)
  - timing constants H_*/V_* and derived totals
  - FRAME_PIXELS = 30000
  - the crop constants shared with the frame stage: 330-byte source stride, 3330 start offset
- One natural sub-module: scan_counter, an instantiable wrap counter with enable, terminal-count flag and compare-window output. Instantiated twice (horizontal, vertical; vertical enabled by the horizontal terminal count).

Test Plan:
- Reset, then FrameReady=1, Enable=1:
  - first readFrame=1 with PxOut=0, LineOut=0, FrameWInd=0
  - after 300 active clks, PxOut=300, readFrame=0, FrameWInd holds 299
- Line 0 horizontal timing: HSync=0 exactly for PxOut 308..323; PxOut wraps 339->0 with LineOut 0->1; on line 1, PxOut=0 gives FrameWInd=300.
- Full frame, CONTINUOUS=0:
  - 30000 readFrame cycles total; FrameDone single pulse after index 29999
  - VSync=0 only on lines 102..103
  - returns to IDLE (Busy=0) after 37400 SCAN clks
- Enable=0 for 5 clks at PxOut=150, LineOut=20: all outputs frozen (FrameWInd=6150); resumes to PxOut=151 / FrameWInd=6151.
- Reset asserted at LineOut=50: next cycle all outputs at reset values, IDLE; a new FrameReady restarts at FrameWInd=0.
- CONTINUOUS=1 with FrameReady held: second frame's FrameWInd=0 arrives exactly 2 clks after the last blanking position (via WRAP); no FrameDone gap or duplicate.
